// File: rtl/dsram.sv
// AXI-lite data scratchpad: word-addressed array with independent read and
// write channel FSMs, programmable response latency and byte-lane strobes.
module dsram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] RD_CNT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0] WR_CNT_INIT = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [IW-1:0] addr_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[IW+1:2];
  endfunction

  function automatic logic addr_ok(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({2'b00, off[31:2]} < DEPTH_WORDS);
  endfunction

  // ---------------- read channel ----------------
  r_state_t      r_state, r_next;
  logic [3:0]    r_cnt;
  logic [IW-1:0] r_idx, r_cap_idx;
  logic          r_ok, r_cap_ok, r_cap;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);

  // With RD_LAT==1 the capture happens on the AR handshake edge itself, so the
  // live address is decoded rather than the latched copy.
  always_comb begin
    r_next    = r_state;
    r_cap     = 1'b0;
    r_cap_idx = r_idx;
    r_cap_ok  = r_ok;
    unique case (r_state)
      R_IDLE: if (arvalid) begin
        r_cap_idx = addr_idx(araddr);
        r_cap_ok  = addr_ok(araddr);
        if (RD_LAT == 1) begin
          r_next = R_RESP;
          r_cap  = 1'b1;
        end else begin
          r_next = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt == '0) begin
        r_next = R_RESP;
        r_cap  = 1'b1;
      end
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_ok  <= 1'b0;
      rdata <= '0;
      rresp <= '0;
    end else begin
      if (r_state == R_IDLE && arvalid) begin
        r_idx <= r_cap_idx;
        r_ok  <= r_cap_ok;
        r_cnt <= RD_CNT_INIT;
      end else if (r_state == R_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_cap) begin
        rdata <= r_cap_ok ? mem[r_cap_idx] : '0;
        rresp <= r_cap_ok ? 2'b00 : 2'b11;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t      w_state, w_next;
  logic [3:0]    w_cnt;
  logic          aw_got, w_got, aw_hs, w_hs, commit;
  logic [IW-1:0] aw_idx, c_idx;
  logic          aw_ok, c_ok;
  logic [31:0]   w_data, c_data;
  logic [3:0]    w_strb, c_strb;

  assign awready = (w_state == W_IDLE) && !aw_got;
  assign wready  = (w_state == W_IDLE) && !w_got;
  assign bvalid  = (w_state == W_RESP);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Commit operands come from the live bus for whichever half is handshaking
  // in the commit cycle, otherwise from the captured copy.
  always_comb begin
    c_idx  = aw_got ? aw_idx : addr_idx(awaddr);
    c_ok   = aw_got ? aw_ok  : addr_ok(awaddr);
    c_data = w_got  ? w_data : wdata;
    c_strb = w_got  ? w_strb : wstrb;
    w_next = w_state;
    commit = 1'b0;
    unique case (w_state)
      W_IDLE: if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        if (WR_LAT == 1) begin
          w_next = W_RESP;
          commit = 1'b1;
        end else begin
          w_next = W_WAIT;
        end
      end
      W_WAIT: if (w_cnt == '0) begin
        w_next = W_RESP;
        commit = 1'b1;
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt  <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_idx <= '0;
      aw_ok  <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
      bresp  <= '0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_idx <= addr_idx(awaddr);
        aw_ok  <= addr_ok(awaddr);
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (w_state == W_IDLE && w_next == W_WAIT) w_cnt <= WR_CNT_INIT;
      else if (w_state == W_WAIT && w_cnt != '0) w_cnt <= w_cnt - 4'd1;
      if (commit) bresp <= c_ok ? 2'b00 : 2'b11;
      if (w_state == W_RESP && bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dsram.sv
// Directed bench for dsram: a table of single transactions on a RD_LAT=1/WR_LAT=1
// instance plus hand sequences for collision, ordering/latency and reset on a slow one.
module tb_dsram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, awvalid, wvalid, rready, bready;

  logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a;
  logic        arready_b, rvalid_b, awready_b, wready_b, bvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  rresp_a, rresp_b, bresp_a, bresp_b;

  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  dsram #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .RD_LAT(1), .WR_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid && !sel), .arready(arready_a),
    .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready && !sel),
    .awaddr(awaddr), .awvalid(awvalid && !sel), .awready(awready_a),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid && !sel), .wready(wready_a),
    .bresp(bresp_a), .bvalid(bvalid_a), .bready(bready && !sel)
  );

  dsram #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .RD_LAT(4), .WR_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid && sel), .arready(arready_b),
    .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready && sel),
    .awaddr(awaddr), .awvalid(awvalid && sel), .awready(awready_b),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid && sel), .wready(wready_b),
    .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready && sel)
  );

  assign arready = sel ? arready_b : arready_a;
  assign rvalid  = sel ? rvalid_b  : rvalid_a;
  assign rdata   = sel ? rdata_b   : rdata_a;
  assign rresp   = sel ? rresp_b   : rresp_a;
  assign awready = sel ? awready_b : awready_a;
  assign wready  = sel ? wready_b  : wready_a;
  assign bvalid  = sel ? bvalid_b  : bvalid_a;
  assign bresp   = sel ? bresp_b   : bresp_a;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] er, input logic [31:0] ed);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_resp = er; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  // Starts and ends on a falling edge; lat counts cycles from the AR handshake.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    araddr = addr; arvalid = 1'b1; n = 0; lat = 99;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (arready) begin
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    end
    arvalid = 1'b0;
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  // lat counts cycles from the later of the AW/W handshakes.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold, input logic [1:0] exp_resp,
                          output logic [1:0] resp, output int lat, output bit rdy_err);
    bit aw_done, w_done, hs_aw, hs_w;
    int t;
    aw_done = 0; w_done = 0; t = 0; rdy_err = 0; lat = 99;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && t < 50) begin
      awvalid = (t >= aw_dly) && !aw_done;
      wvalid  = (t >= w_dly) && !w_done;
      if ((aw_done && awready) || (w_done && wready)) rdy_err = 1;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk);
      aw_done |= hs_aw;
      w_done  |= hs_w;
      @(negedge clk);
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (aw_done && w_done) begin
      lat = 1;
      while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    end
    resp = bresp;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("bresp_hold", 32'(bresp), 32'(exp_resp));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clear", 32'(bvalid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          rerr, seen;

    rst_n = 1'b0; sel = 1'b0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_arready", 32'(arready), 32'd1);
      check("rst_awready", 32'(awready), 32'd1);
      check("rst_wready",  32'(wready),  32'd1);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rdata",   rdata,        32'd0);
      check("rst_rresp",   32'(rresp),   32'd0);
      check("rst_bresp",   32'(bresp),   32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    add_vec(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0);
    add_vec(0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF);
    add_vec(1, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0);
    add_vec(1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0);
    add_vec(0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD);
    add_vec(1, 32'h8000_0020, 32'h9988_7766, 4'hA, 2'b00, 32'h0);
    add_vec(0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'h99BB_77DD);
    add_vec(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0);
    add_vec(0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b11, 32'h0);
    add_vec(0, 32'h8000_1000, 32'h0,         4'h0, 2'b11, 32'h0);
    add_vec(1, 32'h8000_1000, 32'h1234_5678, 4'hF, 2'b11, 32'h0);
    add_vec(0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D);
    add_vec(1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0);
    add_vec(0, 32'h8000_0013, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF);
    add_vec(1, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, 2'b00, 32'h0);
    add_vec(0, 32'h8000_0FFC, 32'h0,         4'h0, 2'b00, 32'h0BAD_CAFE);
    add_vec(0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b11, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, vecs[i].exp_resp, r, lat, rerr);
        check($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_blat", i), 32'(lat), 32'd1);
      end else begin
        do_read(vecs[i].addr, d, r, lat);
        check($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("v%0d_rlat", i), 32'(lat), 32'd1);
      end
    end

    // Same-edge read capture and write commit on word 5.
    do_write(32'h8000_0014, 32'h0, 4'hF, 0, 0, 0, 2'b00, r, lat, rerr);
    araddr = 32'h8000_0014; awaddr = 32'h8000_0014; wdata = 32'h5555_5555; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_rdata",  rdata,       32'h0);
    check("coll_bvalid", 32'(bvalid), 32'd1);
    check("coll_bresp",  32'(bresp),  32'd0);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0014, d, r, lat);
    check("coll_after_rdata", d, 32'h5555_5555);

    // Slow instance: W three cycles ahead of AW, response back-pressured.
    sel = 1'b1;
    @(negedge clk);
    do_write(32'h8000_0040, 32'h1357_9BDF, 4'hF, 3, 0, 5, 2'b00, r, lat, rerr);
    check("ord_blat",   32'(lat),  32'd3);
    check("ord_bresp",  32'(r),    32'd0);
    check("ord_ready",  32'(rerr), 32'd0);
    do_read(32'h8000_0040, d, r, lat);
    check("slow_rdata", d,         32'h1357_9BDF);
    check("slow_rlat",  32'(lat),  32'd4);

    // Reset while the slow read is sitting in its wait state.
    araddr = 32'h8000_0040; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rstw_rvalid_pre", 32'(rvalid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_rvalid",  32'(rvalid),  32'd0);
    check("rstw_arready", 32'(arready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    check("rstw_no_resp", 32'(seen), 32'd0);
    do_read(32'h8000_0040, d, r, lat);
    check("rstw_rdata", d,        32'h1357_9BDF);
    check("rstw_rresp", 32'(r),   32'd0);
    check("rstw_rlat",  32'(lat), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsram.md
DSRAM -- requirements
Module: dsram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-003 SHALL have parameter RD_LAT, default 1, cycles from AR handshake to rvalid (legal range 1..15).
REQ-004 SHALL have parameter WR_LAT, default 1, cycles from the later of AW/W handshake to bvalid (legal range 1..15).
REQ-005 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have the AXI-lite read ports: araddr in 32; arvalid in 1; arready out 1; rdata out 32; rresp out 2; rvalid out 1; rready in 1.
REQ-008 SHALL have the AXI-lite write ports: awaddr in 32; awvalid in 1; awready out 1; wdata in 32; wstrb in 4; wvalid in 1; wready out 1; bresp out 2; bvalid out 1; bready in 1.

Function
REQ-009 SHALL decode index = (addr - BASE_ADDR) >> 2; in range iff addr >= BASE_ADDR and index < DEPTH_WORDS; addr[1:0] ignored (LSU performs lane alignment).
REQ-010 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready = (state == R_IDLE).
REQ-011 R_IDLE: on arvalid&arready, latch index/range; go R_RESP if RD_LAT==1, else load counter with RD_LAT-2 and go R_WAIT.
REQ-012 R_WAIT: decrement counter each cycle; on counter==0 go R_RESP.
REQ-013 On entry to R_RESP, rdata SHALL register mem[index] and rresp 2'b00 (OKAY), or rdata 0 and rresp 2'b11 (DECERR) if out of range.
REQ-014 R_RESP: rvalid=1, rdata/rresp stable until rready; on rvalid&rready go R_IDLE; next AR accepted no earlier than the following cycle.
REQ-015 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP.
REQ-016 W_IDLE: awready=1 until AW captured, wready=1 until W captured; AW and W accepted independently in either order or the same cycle; each captured exactly once per transaction.
REQ-017 When both AW and W are captured (cycle of the later handshake), SHALL go W_RESP if WR_LAT==1, else load counter WR_LAT-2 and go W_WAIT; awready=wready=0 outside W_IDLE.
REQ-018 On entry to W_RESP, SHALL commit the write: for each i, if wstrb[i] then mem[index][8i+7:8i] = wdata[8i+7:8i]; bresp 2'b00; if out of range no array change and bresp 2'b11.
REQ-019 W_RESP: bvalid=1, bresp stable until bready; on bvalid&bready return to W_IDLE with both capture flags clear.
REQ-020 wstrb==4'b0000 in range SHALL complete with OKAY and no data change.
REQ-021 Read and write FSMs SHALL run concurrently; if the read capture (REQ-013) and write commit (REQ-018) hit the same index in the same cycle, rdata SHALL return the old (pre-write) value.
REQ-022 Single outstanding transaction per channel pair; no reordering, no bursts.

Reset
REQ-023 While rst_n=0: both FSMs IDLE, counters 0, capture flags 0; arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-024 Reset asserted mid-transaction SHALL abandon it: pending write not committed unless its commit edge already occurred; no response is issued after release.
REQ-025 Array contents SHALL NOT be reset.

Verification
REQ-026 RD_LAT=1: write 32'hDEAD_BEEF to 0x8000_0010 (wstrb 4'hF), read 0x8000_0010 -> rvalid 1 cycle after AR handshake, rdata 32'hDEAD_BEEF, rresp 0.
REQ-027 Partial strobe: word 0x8000_0020 = 32'h1122_3344, write wdata 32'hAABB_CCDD wstrb 4'b0101 -> readback 32'h11BB_33DD.
REQ-028 Ordering: W handshake 3 cycles before AW, WR_LAT=3 -> bvalid exactly 3 cycles after AW handshake; bready held 0 for 5 cycles -> bvalid, bresp held stable.
REQ-029 Decode error: read 0x7FFF_FFFC and 0x8000_1000 (DEPTH_WORDS=1024) -> rresp 2'b11, rdata 0; write 0x8000_1000 -> bresp 2'b11, word 0 unchanged.
REQ-030 Collision: word 5 = 32'h0, read commit and write 32'h5555_5555 commit same cycle on word 5 -> rdata 32'h0; subsequent read -> 32'h5555_5555.
REQ-031 Reset mid-read in R_WAIT (RD_LAT=4) -> rvalid stays 0, arready=1 immediately; fresh read after release completes normally.
